oc8051_alu_unit: RTL and testbench

- 8-bit arithmetic/logic unit of the 8051 CPU core.
- The instruction decoder supplies a 4-bit operation code. The source selector supplies three operands plus carry and aux-carry.
- Results go back to the accumulator, RAM/SFR write data and PSW flags.
- All operations are combinational except MUL and DIV, which are iterative over 4 cycles.

---
 rtl/oc8051_alu_unit_if.sv | 26 ++
 rtl/oc8051_alu_unit.sv | 160 ++++++++++++++++
 tb/tb_oc8051_alu_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/oc8051_alu_unit_if.sv
// Operand/result bundle between the 8051 decoder/source selector and the ALU.
interface oc8051_alu_unit_if;
    logic [3:0] op_code;
    logic [7:0] src1;
    logic [7:0] src2;
    logic [7:0] src3;
    logic       srcCy;
    logic       srcAc;
    logic       bit_in;
    logic [7:0] des_acc;
    logic [7:0] des1;
    logic [7:0] des2;
    logic [7:0] sub_result;
    logic       desCy;
    logic       desAc;
    logic       desOv;

    modport master (
        output op_code, src1, src2, src3, srcCy, srcAc, bit_in,
        input  des_acc, des1, des2, sub_result, desCy, desAc, desOv
    );
    modport slave (
        input  op_code, src1, src2, src3, srcCy, srcAc, bit_in,
        output des_acc, des1, des2, sub_result, desCy, desAc, desOv
    );
endinterface

// File: rtl/oc8051_alu_unit.sv
// 8051 ALU: combinational arithmetic/logic ops plus 4-cycle iterative MUL/DIV.
module oc8051_alu_unit (
    input logic               clk,
    input logic               rst,
    oc8051_alu_unit_if.slave  alu
);
    localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_MUL = 4'h3, OP_DIV = 4'h4,
                           OP_DA  = 4'h5, OP_NOT = 4'h6, OP_AND = 4'h7, OP_XOR = 4'h8,
                           OP_OR  = 4'h9, OP_RL  = 4'hA, OP_RLC = 4'hB, OP_RR  = 4'hC,
                           OP_RRC = 4'hD, OP_INC = 4'hE, OP_XCH = 4'hF;

    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] mul_q, mul_d;
    logic [7:0]  rem_q, rem_d, quo_q, quo_d;
    logic        muldiv;

    logic [15:0] mul_base, mul_pp;
    logic [1:0]  mul_bits;
    logic [7:0]  div_r, div_q, div_dvd, div_r1;
    logic [8:0]  div_t1, div_t2, div_den;
    logic        div_q1, div_q2;

    logic [4:0]  add_lo, sub_lo;
    logic [7:0]  add_6;
    logic [8:0]  add_f, sub_f, da1, da2;
    logic [15:0] inc_v;

    assign muldiv = (alu.op_code == OP_MUL) || (alu.op_code == OP_DIV);
    assign cnt_d  = muldiv ? cnt_q + 2'd1 : 2'd0;

    // Each cycle folds in two multiplier bits (LSB first) and two dividend bits
    // (MSB first); count 0 ignores stored state so an aborted op leaves no trace.
    always_comb begin
        mul_base = (cnt_q == 2'd0) ? 16'h0 : mul_q;
        mul_bits = alu.src2[{cnt_q, 1'b0} +: 2];
        mul_pp   = ({8'h0, alu.src1} & {16{mul_bits[0]}}) +
                   ({7'h0, alu.src1, 1'b0} & {16{mul_bits[1]}});
        mul_d    = mul_base + (mul_pp << {cnt_q, 1'b0});

        div_r   = (cnt_q == 2'd0) ? 8'h0 : rem_q;
        div_q   = (cnt_q == 2'd0) ? 8'h0 : quo_q;
        div_dvd = alu.src1 << {cnt_q, 1'b0};
        div_den = {1'b0, alu.src2};
        div_t1  = {div_r, div_dvd[7]};
        div_q1  = div_t1 >= div_den;
        div_r1  = div_q1 ? 8'(div_t1 - div_den) : div_t1[7:0];
        div_t2  = {div_r1, div_dvd[6]};
        div_q2  = div_t2 >= div_den;
        rem_d   = div_q2 ? 8'(div_t2 - div_den) : div_t2[7:0];
        quo_d   = {div_q[5:0], div_q1, div_q2};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
            mul_q <= 16'h0;
            rem_q <= 8'h0;
            quo_q <= 8'h0;
        end else begin
            cnt_q <= cnt_d;
            mul_q <= mul_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

    assign add_lo = {1'b0, alu.src1[3:0]} + {1'b0, alu.src2[3:0]} + {4'h0, alu.srcCy};
    assign add_6  = {1'b0, alu.src1[6:0]} + {1'b0, alu.src2[6:0]} + {7'h0, alu.srcCy};
    assign add_f  = {1'b0, alu.src1} + {1'b0, alu.src2} + {8'h0, alu.srcCy};
    assign sub_lo = {1'b0, alu.src1[3:0]} - {1'b0, alu.src2[3:0]} - {4'h0, alu.srcCy};
    assign sub_f  = {1'b0, alu.src1} - {1'b0, alu.src2} - {8'h0, alu.srcCy};
    assign da1    = ((alu.src1[3:0] > 4'd9) || alu.srcAc) ? {1'b0, alu.src1} + 9'h006
                                                          : {1'b0, alu.src1};
    assign da2    = ((da1[7:4] > 4'd9) || alu.srcCy || da1[8]) ? {1'b0, da1[7:0]} + 9'h060
                                                                : {1'b0, da1[7:0]};
    assign inc_v  = {alu.src2, alu.src1} + (alu.srcCy ? 16'hFFFF : 16'h0001);
    assign alu.sub_result = alu.src1 - alu.src2;

    always_comb begin
        alu.des_acc = alu.src1;
        alu.des1    = alu.src1;
        alu.des2    = alu.src2;
        alu.desCy   = alu.srcCy;
        alu.desAc   = alu.srcAc;
        alu.desOv   = 1'b0;
        case (alu.op_code)
            OP_ADD: begin
                alu.des_acc = add_f[7:0];
                alu.desCy   = add_f[8];
                alu.desAc   = add_lo[4];
                alu.desOv   = add_f[8] ^ add_6[7];
                alu.des2    = alu.src3 + {7'h0, add_f[8]};
            end
            OP_SUB: begin
                alu.des_acc = sub_f[7:0];
                alu.desCy   = sub_f[8];
                alu.desAc   = sub_lo[4];
                alu.desOv   = (alu.src1[7] ^ alu.src2[7]) & (sub_f[7] ^ alu.src1[7]);
                alu.des2    = alu.src3 - {7'h0, sub_f[8]};
            end
            OP_MUL: begin
                alu.des_acc = mul_d[7:0];
                alu.des2    = mul_d[15:8];
                alu.desCy   = 1'b0;
                alu.desOv   = |mul_d[15:8];
            end
            OP_DIV: begin
                alu.desCy   = 1'b0;
                alu.desOv   = (alu.src2 == 8'h0);
                alu.des_acc = (alu.src2 == 8'h0) ? 8'hFF : quo_d;
                alu.des2    = (alu.src2 == 8'h0) ? alu.src1 : rem_d;
            end
            OP_DA: begin
                alu.des_acc = da2[7:0];
                alu.desCy   = alu.srcCy | da1[8] | da2[8];
            end
            OP_NOT: begin
                alu.des_acc = ~alu.src1;
                alu.desCy   = ~alu.bit_in;
            end
            OP_AND: begin
                alu.des_acc = alu.src1 & alu.src2;
                alu.desCy   = alu.srcCy & alu.bit_in;
            end
            OP_XOR: begin
                alu.des_acc = alu.src1 ^ alu.src2;
                alu.desCy   = alu.srcCy ^ alu.bit_in;
            end
            OP_OR: begin
                alu.des_acc = alu.src1 | alu.src2;
                alu.desCy   = alu.srcCy | alu.bit_in;
            end
            OP_RL:  alu.des_acc = {alu.src1[6:0], alu.src1[7]};
            OP_RLC: begin
                alu.des_acc = {alu.src1[6:0], alu.srcCy};
                alu.desCy   = alu.src1[7];
            end
            OP_RR:  alu.des_acc = {alu.src1[0], alu.src1[7:1]};
            OP_RRC: begin
                alu.des_acc = {alu.srcCy, alu.src1[7:1]};
                alu.desCy   = alu.src1[0];
            end
            OP_INC: begin
                alu.des_acc = inc_v[7:0];
                alu.des1    = inc_v[7:0];
                alu.des2    = inc_v[15:8];
            end
            OP_XCH: begin
                if (alu.srcCy) begin
                    alu.des_acc = {alu.src1[7:4], alu.src2[3:0]};
                    alu.des1    = {alu.src2[7:4], alu.src1[3:0]};
                end else begin
                    alu.des_acc = alu.src2;
                    alu.des1    = alu.src1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_oc8051_alu_unit.sv
// Directed and randomized checks of oc8051_alu_unit against an arithmetic reference model.
module tb_oc8051_alu_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    oc8051_alu_unit_if bus ();
    oc8051_alu_unit dut (.clk(clk), .rst(rst), .alu(bus));

    always #5 clk = ~clk;

    function automatic int sgn(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    // Expected {des_acc, des1, des2, sub_result, desCy, desAc, desOv}.
    function automatic logic [34:0] model(input int op, input int s1, input int s2,
                                          input int s3, input bit cy, input bit ac,
                                          input bit bi);
        int acc = s1, d1 = s1, d2 = s2, sub = (s1 - s2) & 255;
        bit c = cy, a = ac, o = 1'b0, c1;
        int t, sv;
        case (op)
            1: begin
                t = s1 + s2 + int'(cy); acc = t & 255; c = t > 255;
                a = ((s1 & 15) + (s2 & 15) + int'(cy)) > 15;
                sv = sgn(s1) + sgn(s2) + int'(cy); o = (sv > 127) || (sv < -128);
                d2 = (s3 + int'(c)) & 255;
            end
            2: begin
                t = s1 - s2 - int'(cy); acc = t & 255; c = t < 0;
                a = ((s1 & 15) - (s2 & 15) - int'(cy)) < 0;
                sv = sgn(s1) - sgn(s2) - int'(cy); o = (sv > 127) || (sv < -128);
                d2 = (s3 - int'(c)) & 255;
            end
            3: begin
                t = s1 * s2; acc = t & 255; d2 = t >> 8; c = 1'b0; o = t > 255;
            end
            4: begin
                c = 1'b0;
                if (s2 == 0) begin o = 1'b1; acc = 255; d2 = s1; end
                else begin acc = s1 / s2; d2 = s1 % s2; end
            end
            5: begin
                t = s1;
                if ((t & 15) > 9 || ac) t = t + 6;
                c1 = t > 255; t = t & 255;
                if ((t >> 4) > 9 || cy || c1) t = t + 96;
                c = cy | c1 | (t > 255); acc = t & 255;
            end
            6: begin acc = ~s1 & 255; c = !bi; end
            7: begin acc = s1 & s2; c = cy & bi; end
            8: begin acc = s1 ^ s2; c = cy ^ bi; end
            9: begin acc = s1 | s2; c = cy | bi; end
            10: acc = ((s1 << 1) | (s1 >> 7)) & 255;
            11: begin acc = ((s1 << 1) | int'(cy)) & 255; c = ((s1 >> 7) & 1) == 1; end
            12: acc = (s1 >> 1) | ((s1 & 1) << 7);
            13: begin acc = (s1 >> 1) | (int'(cy) << 7); c = (s1 & 1) == 1; end
            14: begin
                t = (s2 * 256 + s1 + (cy ? -1 : 1)) & 65535;
                acc = t & 255; d1 = acc; d2 = t >> 8;
            end
            15: begin
                if (!cy) begin acc = s2; d1 = s1; end
                else begin acc = (s1 & 240) | (s2 & 15); d1 = (s2 & 240) | (s1 & 15); end
            end
            default: ;
        endcase
        return {8'(acc), 8'(d1), 8'(d2), 8'(sub), c, a, o};
    endfunction

    function automatic logic [34:0] observe();
        return {bus.des_acc, bus.des1, bus.des2, bus.sub_result, bus.desCy, bus.desAc, bus.desOv};
    endfunction

    task automatic apply(input int op, input int s1, input int s2, input int s3,
                         input bit cy, input bit ac, input bit bi);
        bus.op_code = 4'(op); bus.src1 = 8'(s1); bus.src2 = 8'(s2); bus.src3 = 8'(s3);
        bus.srcCy = cy; bus.srcAc = ac; bus.bit_in = bi;
    endtask

    task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Combinational op: drive at negedge, check 1ns later.
    task automatic comb(input string tag, input int op, input int s1, input int s2,
                        input int s3, input bit cy, input bit ac, input bit bi);
        @(negedge clk);
        apply(op, s1, s2, s3, cy, ac, bi);
        #1 check(tag, observe(), model(op, s1, s2, s3, cy, ac, bi));
    endtask

    // Idle one cycle so the counter is at 0, then hold MUL/DIV and check on the 4th cycle.
    task automatic muldiv(input string tag, input int op, input int s1, input int s2);
        @(negedge clk);
        apply(0, s1, s2, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        apply(op, s1, s2, 0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 check(tag, observe(), model(op, s1, s2, 0, 1'b0, 1'b0, 1'b0));
    endtask

    initial begin
        int op, s1, s2, s3;
        bit cy, ac, bi;

        // Reset with NOP: pass-through
        apply(0, 8'h5A, 8'hC3, 8'h11, 1'b1, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 check("rst_passthru", observe(), {8'h5A, 8'h5A, 8'hC3, 8'h97, 1'b1, 1'b1, 1'b0});
        rst = 1'b0;

        // Directed plan values
        comb("add_7f", 1, 8'h7F, 8'h01, 8'h12, 1'b0, 1'b0, 1'b0);
        check("add_7f_val", observe(), {8'h80, 8'h7F, 8'h12, 8'h7E, 1'b1 ^ 1'b1, 1'b1, 1'b1});
        comb("add_ff", 1, 8'hFF, 8'h01, 8'h34, 1'b1, 1'b0, 1'b0);
        check("add_ff_val", {bus.des_acc, bus.desCy, bus.des2}, {8'h01, 1'b1, 8'h35});
        comb("sub_cmp", 2, 8'h10, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0);
        check("sub_cmp_val", {bus.des_acc, bus.desCy, bus.sub_result}, {8'hF0, 1'b1, 8'hF0});
        comb("da_9b", 5, 8'h9B, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        check("da_9b_val", {bus.des_acc, bus.desCy}, {8'h01, 1'b1});
        comb("rlc_81", 11, 8'h81, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        check("rlc_81_val", {bus.des_acc, bus.desCy}, {8'h02, 1'b1});
        comb("inc_12ff", 14, 8'hFF, 8'h12, 8'h00, 1'b0, 1'b0, 1'b0);
        check("inc_12ff_val", {bus.des2, bus.des1}, {8'h13, 8'h00});
        comb("dec_0000", 14, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        check("dec_0000_val", {bus.des2, bus.des1}, {8'hFF, 8'hFF});
        comb("xchd", 15, 8'hAB, 8'hCD, 8'h00, 1'b1, 1'b0, 1'b0);
        check("xchd_val", {bus.des_acc, bus.des1}, {8'hAD, 8'hCB});

        muldiv("mul_50a0", 3, 8'h50, 8'hA0);
        check("mul_50a0_val", {bus.des_acc, bus.des2, bus.desOv, bus.desCy}, {8'h00, 8'h32, 1'b1, 1'b0});
        // Keep holding: the 5th cycle restarts, so the 8th cycle shows the result again
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1 check("mul_wrap", {bus.des_acc, bus.des2}, {8'h00, 8'h32});
        muldiv("div_fb12", 4, 8'hFB, 8'h12);
        check("div_fb12_val", {bus.des_acc, bus.des2, bus.desOv}, {8'h0D, 8'h11, 1'b0});
        muldiv("div_zero", 4, 8'h37, 8'h00);
        check("div_zero_ov", {bus.desOv, bus.des_acc, bus.des2}, {1'b1, 8'hFF, 8'h37});

        // Reset during MUL cycle 2, then hold MUL: result only on the 4th cycle after release
        @(negedge clk); apply(0, 8'h50, 8'hA0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); apply(3, 8'h50, 8'hA0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 begin
            n_cmp++;
            assert ({bus.des_acc, bus.des2} !== 16'h3200) else begin
                n_err++;
                $error("FAIL mul_rst_early: observed %h expected not 3200", {bus.des_acc, bus.des2});
            end
        end
        @(posedge clk);
        @(negedge clk);
        #1 check("mul_rst_4th", {bus.des_acc, bus.des2}, {8'h00, 8'h32});

        // NOP mid-DIV returns the counter to 0
        @(negedge clk); apply(0, 8'hFB, 8'h12, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); apply(4, 8'hFB, 8'h12, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); apply(0, 8'hFB, 8'h12, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); apply(4, 8'hFB, 8'h12, 0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 check("div_abort", {bus.des_acc, bus.des2}, {8'h0D, 8'h11});

        // Randomized sweep over every opcode
        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(0, 15));
            s1 = int'($urandom_range(0, 255));
            s2 = int'($urandom_range(0, 255));
            s3 = int'($urandom_range(0, 255));
            cy = 1'($urandom); ac = 1'($urandom); bi = 1'($urandom);
            if (i % 16 == 0) s2 = 0;
            if (op == 3 || op == 4) muldiv($sformatf("rnd%0d_op%0d", i, op), op, s1, s2);
            else comb($sformatf("rnd%0d_op%0d", i, op), op, s1, s2, s3, cy, ac, bi);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
